buffer_reader: RTL
==================

// Module: buffer_reader
// PURPOSE
// Consumer-side companion to the buffer FIFO. Drives the FIFO's consume strobe, absorbs
// its 1-cycle registered read latency, and re-presents words on a valid/ready stream
// with full throughput under backpressure. Sits between a buffer instance and any
// downstream stage that needs a stall-able handshake; also provides a flush and a transfer count.
// PARAMETERS
// buffer_width  64  data width; must match the attached buffer
// skid_depth    2   internal output queue entries (>=2; 2 gives 1 word/cycle)
// cnt_width     32  width of word_count
// PORTS
// clk          in   1             clock, all state on posedge
// rst          in   1             reset, asynchronous, active-low
// buf_empty    in   1             FIFO empty flag
// buf_out      in   buffer_width  FIFO registered read data
// buf_consume  out  1             FIFO consume strobe (combinational)
// out_data     out  buffer_width  downstream data = queue head
// out_valid    out  1             queue non-empty and state RUN
// out_ready    in   1             downstream accept
// flush        in   1             discard queued and in-flight words
// busy         out  1             q_cnt!=0 | inflight | state!=RUN
// word_count   out  cnt_width     words accepted downstream, wraps
// BEHAVIOUR
// - rst low (async): state=RUN, q_cnt=0, inflight=0, queue ptrs=0, word_count=0;
//   out_valid=0, out_data=0, busy=0, buf_consume=0 while rst low.
// - pop = out_valid & out_ready. Queue FIFO order preserved; pointers wrap at skid_depth.
// - buf_consume = (state==RUN) & ~flush & ~buf_empty & (q_cnt+inflight-pop < skid_depth).
//   Never asserted while buf_empty=1 (FIFO would load 0).
// - inflight <= buf_consume. When inflight=1 in RUN, buf_out is written to queue tail.
// - Latency: consume in cycle N -> buf_out valid N+1 -> captured at end of N+1 ->
//   out_valid in N+2. Capture and pop in same cycle: q_cnt unchanged.
// - Steady state with out_ready=1 and FIFO non-empty: 1 word/cycle.
// - out_ready low: fetch stops once q_cnt+inflight==skid_depth; no word lost or duplicated.
// - word_count += 1 on pop; wraps 2^cnt_width-1 -> 0; unaffected by flush.
// - FSM: RUN: flush=1 -> DRAIN (same cycle: buf_consume=0, out_valid=0).
//   DRAIN: q_cnt<=0, ptrs<=0; arriving in-flight word dropped; buf_consume=0, out_valid=0;
//   -> RUN when flush=0 and inflight=0. Holding flush holds DRAIN.
// - Flush never consumes FIFO words itself; words still in FIFO remain there.
// - rst mid-transfer: in-flight word is lost (FIFO head already advanced); documented, not an error.
// TESTING
// - rst low 3 cycles, release, buf_empty=1 -> buf_consume=0, out_valid=0, busy=0, word_count=0.
// - FIFO holds one word 0xA5, out_ready=1 -> consume cycle N, out_valid+0xA5 in N+2, word_count=1.
// - 8 words 1..8 preloaded, out_ready=1 -> consume 8 consecutive cycles, out 1..8 back-to-back.
// - 8 words, out_ready=0 for 10 cycles then 1 -> only 2 consumes while stalled; then 1..8 in order.
// - flush in cycle after a consume with q_cnt=1 -> in-flight word dropped, out_valid=0,
//   next fetch after flush low returns next FIFO word; word_count unchanged.
// - word_count at 2^cnt_width-1 (cnt_width=4: 15), one pop -> 0.

Source files
------------

// File: rtl/buffer_reader_if.sv
// buffer_reader_if: FIFO-side and stream-side signals of buffer_reader.
// master is the reader, slave is whatever surrounds it.
interface buffer_reader_if #(
    parameter int buffer_width = 64,
    parameter int cnt_width    = 32
);
    logic                    buf_empty;
    logic [buffer_width-1:0] buf_out;
    logic                    buf_consume;
    logic [buffer_width-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush;
    logic                    busy;
    logic [cnt_width-1:0]    word_count;

    modport master (
        input  buf_empty, buf_out, out_ready, flush,
        output buf_consume, out_data, out_valid, busy, word_count
    );

    modport slave (
        output buf_empty, buf_out, out_ready, flush,
        input  buf_consume, out_data, out_valid, busy, word_count
    );
endinterface

// File: rtl/buffer_reader.sv
// buffer_reader: consumer side of the buffer FIFO, re-presents its
// registered read data on a stall-able valid/ready stream.
module buffer_reader #(
    parameter int buffer_width = 64,
    parameter int skid_depth   = 2,
    parameter int cnt_width    = 32
) (
    input  logic            clk,
    input  logic            rst,
    buffer_reader_if.master bus
);
    localparam int CW = $clog2(skid_depth + 1);
    localparam int PW = (skid_depth > 1) ? $clog2(skid_depth) : 1;
    localparam logic [CW:0]   DEPTH = (CW + 1)'(skid_depth);
    localparam logic [PW-1:0] PMAX  = PW'(skid_depth - 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                  state_q;
    logic [CW-1:0]           q_cnt_q;
    logic [CW-1:0]           q_cnt_d;
    logic [PW-1:0]           rd_ptr_q;
    logic [PW-1:0]           wr_ptr_q;
    logic                    inflight_q;
    logic [cnt_width-1:0]    word_count_q;
    logic [buffer_width-1:0] mem_q [skid_depth];

    logic        run;
    logic        pop;
    logic        cap;
    logic [CW:0] occ;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PMAX) ? '0 : p + PW'(1);
    endfunction

    // A flush gates the stream in the very cycle it is raised.
    assign run = (state_q == RUN) & ~bus.flush;
    assign pop = bus.out_valid & bus.out_ready;
    assign cap = run & inflight_q;

    // Slots already promised: queued words plus the word in flight,
    // minus the one leaving this cycle.
    assign occ = {1'b0, q_cnt_q}
               + {{CW{1'b0}}, inflight_q}
               - {{CW{1'b0}}, pop};

    assign bus.buf_consume = rst & run & ~bus.buf_empty & (occ < DEPTH);
    assign bus.out_valid   = run & (q_cnt_q != '0);
    assign bus.out_data    = mem_q[rd_ptr_q];
    assign bus.busy        = (q_cnt_q != '0) | inflight_q | (state_q != RUN);
    assign bus.word_count  = word_count_q;

    always_comb begin
        q_cnt_d = q_cnt_q + CW'(cap) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            q_cnt_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            inflight_q   <= 1'b0;
            word_count_q <= '0;
            for (int i = 0; i < skid_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            inflight_q <= bus.buf_consume;
            if (pop) begin
                word_count_q <= word_count_q + cnt_width'(1);
            end
            unique case (state_q)
                RUN: begin
                    if (bus.flush) begin
                        state_q  <= DRAIN;
                        q_cnt_q  <= '0;
                        rd_ptr_q <= '0;
                        wr_ptr_q <= '0;
                    end else begin
                        if (cap) begin
                            mem_q[wr_ptr_q] <= bus.buf_out;
                            wr_ptr_q        <= nxt(wr_ptr_q);
                        end
                        if (pop) begin
                            rd_ptr_q <= nxt(rd_ptr_q);
                        end
                        q_cnt_q <= q_cnt_d;
                    end
                end
                DRAIN: begin
                    q_cnt_q  <= '0;
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    if (!bus.flush && !inflight_q) begin
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end
endmodule
